// File: rtl/topk_pkg.sv
// topk_pkg: shared types and compare helper for the topk_merge slice.
// Optional build macro TOPK_MERGE_IDX_EN is consumed by topk_merge and topk_merge_net.
package topk_pkg;

    localparam int TOPK_K_DEF = 8;
    localparam int TOPK_MAXW  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } topk_merge_state_e;

    // Operands arrive already sign- or zero-extended to TOPK_MAXW by the caller.
    function automatic logic topk_gt(input logic [TOPK_MAXW-1:0] a,
                                     input logic [TOPK_MAXW-1:0] b,
                                     input logic                 sign);
        if (sign) return $signed(a) > $signed(b);
        return a > b;
    endfunction

endpackage

// File: rtl/topk_merge_net.sv
// topk_merge_net: combinational merge of two descending K-lists into the descending top K.
// With TOPK_MERGE_IDX_EN defined, index lanes follow their data through every stage.
module topk_merge_net
    import topk_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int K         = TOPK_K_DEF,
    parameter int IDXW      = 13
) (
    input  logic [DATAWIDTH-1:0] a [K],
    input  logic [DATAWIDTH-1:0] b [K],
    input  logic                 sign,
`ifdef TOPK_MERGE_IDX_EN
    input  logic [IDXW-1:0]      ia [K],
    input  logic [IDXW-1:0]      ib [K],
    output logic [IDXW-1:0]      ic [K],
`endif
    output logic [DATAWIDTH-1:0] c [K]
);

    localparam int STAGES = $clog2(K);

    function automatic logic [TOPK_MAXW-1:0] ext(input logic [DATAWIDTH-1:0] v, input logic s);
        return s ? TOPK_MAXW'($signed(v)) : TOPK_MAXW'(v);
    endfunction

    logic [DATAWIDTH-1:0] w_d [STAGES+1][K];
`ifdef TOPK_MERGE_IDX_EN
    logic [IDXW-1:0]      w_i [STAGES+1][K];
`endif

    // Pairing a[i] with b[K-1-i] leaves a bitonic list holding exactly the top K.
    for (genvar i = 0; i < K; i++) begin : g_max
        logic w_take_b;
        assign w_take_b  = topk_gt(ext(b[K-1-i], sign), ext(a[i], sign), sign);
        assign w_d[0][i] = w_take_b ? b[K-1-i] : a[i];
`ifdef TOPK_MERGE_IDX_EN
        assign w_i[0][i] = w_take_b ? ib[K-1-i] : ia[i];
`endif
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int DIST = K >> (s + 1);
        for (genvar i = 0; i < K; i++) begin : g_lane
            if ((i & DIST) == 0) begin : g_cx
                logic w_swap;
                assign w_swap              = topk_gt(ext(w_d[s][i+DIST], sign), ext(w_d[s][i], sign), sign);
                assign w_d[s+1][i]         = w_swap ? w_d[s][i+DIST] : w_d[s][i];
                assign w_d[s+1][i+DIST]    = w_swap ? w_d[s][i] : w_d[s][i+DIST];
`ifdef TOPK_MERGE_IDX_EN
                assign w_i[s+1][i]         = w_swap ? w_i[s][i+DIST] : w_i[s][i];
                assign w_i[s+1][i+DIST]    = w_swap ? w_i[s][i] : w_i[s][i+DIST];
`endif
            end
        end
    end

    assign c  = w_d[STAGES];
`ifdef TOPK_MERGE_IDX_EN
    assign ic = w_i[STAGES];
`endif

endmodule

// File: rtl/topk_merge.sv
// topk_merge: streaming top-K accumulator behind the 32-input bitonic sorter.
// Optional TOPK_MERGE_IDX_EN adds idx_o carrying {beat, position} for each result element.
//   state | meaning
//   IDLE  | waiting for the first beat of a frame
//   ACCUM | frame open, merging each beat into best[]
//   DONE  | result held on y_o/beats_o until accepted
module topk_merge
    import topk_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 32,
    parameter int K          = TOPK_K_DEF,
    parameter int CNTWIDTH   = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 sign_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 in_last_i,
    input  logic [DATAWIDTH-1:0] x_i [DATALENGTH],
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATAWIDTH-1:0] y_o [K],
`ifdef TOPK_MERGE_IDX_EN
    output logic [CNTWIDTH+$clog2(DATALENGTH)-1:0] idx_o [K],
`endif
    output logic [CNTWIDTH-1:0]  beats_o
);

    localparam int POSW = $clog2(DATALENGTH);
    localparam int IDXW = CNTWIDTH + POSW;

    topk_merge_state_e    r_state, w_next_state;
    logic [DATAWIDTH-1:0] r_best   [K];
    logic [DATAWIDTH-1:0] w_x_top  [K];
    logic [DATAWIDTH-1:0] w_merged [K];
    logic [CNTWIDTH-1:0]  r_count;
    logic                 r_sign;
    logic                 w_accept;
    logic                 w_first;

    assign in_ready_o  = (r_state != DONE);
    assign out_valid_o = (r_state == DONE);
    assign w_accept    = in_valid_i && in_ready_o;
    assign w_first     = (r_state == IDLE);

    // Input is already sorted, so only its first K elements can reach the result.
    for (genvar i = 0; i < K; i++) begin : g_top
        assign w_x_top[i] = x_i[i];
    end
    if (DATALENGTH > K) begin : g_tail
        logic [DATAWIDTH-1:0] w_tail_unused [DATALENGTH-K];
        for (genvar i = K; i < DATALENGTH; i++) begin : g_t
            assign w_tail_unused[i-K] = x_i[i];
        end
    end

`ifdef TOPK_MERGE_IDX_EN
    logic [IDXW-1:0]     r_idx        [K];
    logic [IDXW-1:0]     w_idx_in     [K];
    logic [IDXW-1:0]     w_idx_merged [K];
    logic [CNTWIDTH-1:0] w_beat;

    assign w_beat = w_first ? '0 : r_count;
    for (genvar i = 0; i < K; i++) begin : g_idx
        assign w_idx_in[i] = {w_beat, POSW'(i)};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_idx <= '{default: '0};
        end else if (w_accept) begin
            if (w_first) r_idx <= w_idx_in;
            else         r_idx <= w_idx_merged;
        end
    end

    assign idx_o = r_idx;
`endif

    topk_merge_net #(
        .DATAWIDTH(DATAWIDTH),
        .K        (K),
        .IDXW     (IDXW)
    ) u_net (
        .a   (r_best),
        .b   (w_x_top),
        .sign(r_sign),
`ifdef TOPK_MERGE_IDX_EN
        .ia  (r_idx),
        .ib  (w_idx_in),
        .ic  (w_idx_merged),
`endif
        .c   (w_merged)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, ACCUM: if (in_valid_i) w_next_state = in_last_i ? DONE : ACCUM;
            DONE:        if (out_ready_i) w_next_state = IDLE;
            default:     w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_best  <= '{default: '0};
            r_count <= '0;
            r_sign  <= 1'b0;
        end else if (w_accept) begin
            if (w_first) begin
                r_best  <= w_x_top;
                r_sign  <= sign_i;
                r_count <= CNTWIDTH'(1);
            end else begin
                r_best <= w_merged;
                if (r_count != '1) r_count <= r_count + CNTWIDTH'(1);
            end
        end
    end

    assign y_o     = r_best;
    assign beats_o = r_count;

endmodule
